// File: rtl/pc_unit.sv
// Program-counter unit: holds the word-address PC and selects the next PC from
// sequential, branch, jump and jump-register sources, with stall and a circular return-address stack.
module pc_unit #(
   parameter int               WIDTH     = 30,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           br_taken,
   input  logic [WIDTH-1:0]               br_offset,
   input  logic                           jump,
   input  logic [WIDTH-1:0]               jump_target,
   input  logic                           call,
   input  logic                           jr,
   input  logic [WIDTH-1:0]               jr_target,
   input  logic                           ret,
   output logic [WIDTH-1:0]               pc,
   output logic [WIDTH-1:0]               pc_plus1,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_overflow,
   output logic                           ras_underflow
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    top;
   logic [PW-1:0]    top_inc;
   logic [PW-1:0]    top_dec;
   logic [WIDTH-1:0] pc_next;
   logic             push;
   logic             pop;
   logic             uf_set;

   assign pc_plus1 = pc + WIDTH'(1);
   assign top_inc  = top + PW'(1);
   assign top_dec  = top - PW'(1);

   // jr outranks jump, so a jr+jump+call cycle never pushes.
   always_comb begin
      pc_next = pc_plus1;
      push    = 1'b0;
      pop     = 1'b0;
      uf_set  = 1'b0;
      if (jr) begin
         if (ret && ras_count != '0) begin
            pc_next = ras_mem[top];
            pop     = 1'b1;
         end else begin
            pc_next = jr_target;
            uf_set  = ret;
         end
      end else if (jump) begin
         pc_next = jump_target;
         push    = call;
      end else if (br_taken) begin
         pc_next = pc_plus1 + br_offset;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_VEC;
         top           <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else if (!stall) begin
         pc <= pc_next;
         if (push) begin
            top <= top_inc;
            // When full the write at top+1 lands on the oldest entry, so the count saturates.
            if (ras_count == FULL) ras_overflow <= 1'b1;
            else                   ras_count    <= ras_count + CW'(1);
         end else if (pop) begin
            top       <= top_dec;
            ras_count <= ras_count - CW'(1);
         end
         if (uf_set) ras_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !stall && push) ras_mem[top_inc] <= pc_plus1;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequencing, branches, jumps, RAS call/return,
// overflow/underflow, stall and mid-sequence reset, with hand-computed expectations.
module tb_pc_unit;

   localparam int W = 30;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic          br_taken;
   logic [W-1:0]  br_offset;
   logic          jump;
   logic [W-1:0]  jump_target;
   logic          call;
   logic          jr;
   logic [W-1:0]  jr_target;
   logic          ret;
   logic [W-1:0]  pc;
   logic [W-1:0]  pc_plus1;
   logic [2:0]    ras_count;
   logic          ras_overflow;
   logic          ras_underflow;

   int n_cmp = 0;
   int n_err = 0;

   pc_unit #(.WIDTH(W), .RESET_VEC(30'h100), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
      .jump(jump), .jump_target(jump_target), .call(call), .jr(jr), .jr_target(jr_target),
      .ret(ret), .pc(pc), .pc_plus1(pc_plus1), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      rst = 0; stall = 0; br_taken = 0; br_offset = '0; jump = 0; jump_target = '0;
      call = 0; jr = 0; jr_target = '0; ret = 0;
   endtask

   // One clock edge, then outputs are sampled 1 time unit later; inputs return to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_jump(input logic [W-1:0] t, input logic c);
      jump = 1; jump_target = t; call = c;
      tick();
   endtask

   task automatic do_ret(input logic [W-1:0] t);
      jr = 1; ret = 1; jr_target = t;
      tick();
   endtask

   initial begin
      idle_inputs();
      // 1: reset and sequential fetch
      rst = 1;
      tick();
      check("rst_pc", pc, 30'h100);
      check("rst_count", ras_count, 0);
      check("rst_ovf", ras_overflow, 0);
      check("rst_udf", ras_underflow, 0);
      for (int i = 0; i < 5; i++) tick();
      check("seq_pc", pc, 30'h105);
      check("seq_plus1", pc_plus1, 30'h106);

      // 2: negative branch offset and PC wrap
      do_jump(30'h010, 0);
      check("jmp_pc", pc, 30'h010);
      br_taken = 1; br_offset = 30'h3FFFFFFD;
      tick();
      check("br_neg", pc, 30'h00E);
      do_jump(30'h3FFFFFFF, 0);
      check("plus1_wrap", pc_plus1, 30'h0);
      tick();
      check("pc_wrap", pc, 30'h0);

      // 3: single call/return
      do_jump(30'h020, 0);
      do_jump(30'h200, 1);
      check("call_pc", pc, 30'h200);
      check("call_count", ras_count, 1);
      do_ret(30'h999);
      check("ret_pc", pc, 30'h021);
      check("ret_count", ras_count, 0);

      // 4: nested calls past depth, then unwind past empty
      do_jump(30'h300, 0);
      do_jump(30'h400, 1);
      do_jump(30'h500, 1);
      do_jump(30'h600, 1);
      do_jump(30'h700, 1);
      check("full_ovf_clear", ras_overflow, 0);
      do_jump(30'h800, 1);
      check("ovf_count", ras_count, 4);
      check("ovf_flag", ras_overflow, 1);
      do_ret(30'h123);
      check("ret4_pc", pc, 30'h701);
      do_ret(30'h123);
      check("ret3_pc", pc, 30'h601);
      do_ret(30'h123);
      check("ret2_pc", pc, 30'h501);
      do_ret(30'h123);
      check("ret1_pc", pc, 30'h401);
      check("ret1_count", ras_count, 0);
      check("udf_clear", ras_underflow, 0);
      do_ret(30'h123);
      check("udf_pc", pc, 30'h123);
      check("udf_flag", ras_underflow, 1);
      check("udf_count", ras_count, 0);

      // 5: stall, jr over jump, unqualified call/ret
      stall = 1; jump = 1; call = 1; jump_target = 30'h777; br_taken = 1; br_offset = 30'h5;
      tick();
      check("stall_pc", pc, 30'h123);
      check("stall_count", ras_count, 0);
      jr = 1; jr_target = 30'h456; jump = 1; jump_target = 30'h789; call = 1;
      tick();
      check("jr_wins_pc", pc, 30'h456);
      check("jr_wins_count", ras_count, 0);
      call = 1;
      tick();
      check("call_alone_pc", pc, 30'h457);
      check("call_alone_count", ras_count, 0);
      do_jump(30'h050, 1);
      check("push_count", ras_count, 1);
      ret = 1;
      tick();
      check("ret_alone_pc", pc, 30'h051);
      check("ret_alone_count", ras_count, 1);
      stall = 1; jr = 1; ret = 1; jr_target = 30'h999;
      tick();
      check("stall_ret_pc", pc, 30'h051);
      check("stall_ret_count", ras_count, 1);
      check("flags_sticky", {ras_overflow, ras_underflow}, 2'b11);

      // 6: reset overrides a concurrent call
      do_jump(30'h060, 1);
      do_jump(30'h070, 1);
      check("pre_rst_count", ras_count, 3);
      rst = 1; jump = 1; call = 1; jump_target = 30'h0AA;
      tick();
      check("rst2_pc", pc, 30'h100);
      check("rst2_count", ras_count, 0);
      check("rst2_ovf", ras_overflow, 0);
      check("rst2_udf", ras_underflow, 0);
      tick();
      check("post_rst_pc", pc, 30'h101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
